// File: rtl/pulse_gen_module.sv
// Idle-high pin driver that emits a programmed train of active-low pulses.
// A single-cycle start latches the operands; a one-cycle done_sig closes each train.
`timescale 1ns/1ps
module pulse_gen_module #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] pulse_num,
  input  logic             abort_sig,
  output logic             pin_out,
  output logic             busy,
  output logic             done_sig,
  output logic [NUM_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
  logic [CNT_W-1:0] low_len_reg, low_len_next;
  logic [CNT_W-1:0] high_len_reg, high_len_next;
  logic [NUM_W-1:0] pulse_num_reg, pulse_num_next;
  logic [NUM_W-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic             pin_reg, busy_reg, done_reg;
  logic             phase_end;
  logic [NUM_W-1:0] cnt_inc;

  // A zero length is treated as one cycle, so the counter is loaded with max(len,1)-1.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - CNT_W'(1));
  endfunction

  assign phase_end = (phase_cnt_reg == '0);
  assign cnt_inc   = pulse_cnt_reg + NUM_W'(1);

  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    low_len_next   = low_len_reg;
    high_len_next  = high_len_reg;
    pulse_num_next = pulse_num_reg;
    pulse_cnt_next = pulse_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start_sig) begin
          low_len_next   = low_len;
          high_len_next  = high_len;
          pulse_num_next = pulse_num;
          pulse_cnt_next = '0;
          if (pulse_num != '0) begin
            state_next     = LOW;
            phase_cnt_next = load_val(low_len);
          end else begin
            state_next = DONE;
          end
        end
      end

      LOW: begin
        // Abort takes priority, so a truncated low phase is never counted.
        if (abort_sig) begin
          state_next = DONE;
        end else if (phase_end) begin
          pulse_cnt_next = cnt_inc;
          if (cnt_inc == pulse_num_reg) begin
            state_next = DONE;
          end else begin
            state_next     = HIGH;
            phase_cnt_next = load_val(high_len_reg);
          end
        end else begin
          phase_cnt_next = phase_cnt_reg - CNT_W'(1);
        end
      end

      HIGH: begin
        if (abort_sig) begin
          state_next = DONE;
        end else if (phase_end) begin
          state_next     = LOW;
          phase_cnt_next = load_val(low_len_reg);
        end else begin
          phase_cnt_next = phase_cnt_reg - CNT_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      low_len_reg   <= '0;
      high_len_reg  <= '0;
      pulse_num_reg <= '0;
      pulse_cnt_reg <= '0;
      pin_reg       <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      low_len_reg   <= low_len_next;
      high_len_reg  <= high_len_next;
      pulse_num_reg <= pulse_num_next;
      pulse_cnt_reg <= pulse_cnt_next;
      // Outputs are decoded from the next state so they line up with state_reg.
      pin_reg       <= (state_next != LOW);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
    end
  end

  assign pin_out   = pin_reg;
  assign busy      = busy_reg;
  assign done_sig  = done_reg;
  assign pulse_cnt = pulse_cnt_reg;

endmodule

// File: tb/tb_pulse_gen_module.sv
// Bench for pulse_gen_module: a train-level reference model checked every cycle,
// plus directed scenarios with hand-computed waveforms.
`timescale 1ns/1ps
module tb_pulse_gen_module;

  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_sig = 1'b0;
  logic             abort_sig = 1'b0;
  logic [CNT_W-1:0] low_len = '0;
  logic [CNT_W-1:0] high_len = '0;
  logic [NUM_W-1:0] pulse_num = '0;
  logic             pin_out;
  logic             busy;
  logic             done_sig;
  logic [NUM_W-1:0] pulse_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_gen_module #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_sig (start_sig),
    .low_len   (low_len),
    .high_len  (high_len),
    .pulse_num (pulse_num),
    .abort_sig (abort_sig),
    .pin_out   (pin_out),
    .busy      (busy),
    .done_sig  (done_sig),
    .pulse_cnt (pulse_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a train is the list of per-cycle (pin, count) pairs.
  int m_mode = 0;   // 0 idle, 1 in train, 2 done cycle
  int m_idx = 0;
  int m_last = 0;
  int m_done_cnt = 0;
  int m_n = 0;
  int m_l = 1;
  int m_h = 1;
  int e_pin, e_busy, e_done, e_cnt;
  bit m_pin[$];
  int m_cnt[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_pin", pin_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_sig, 0);
        chk("rst_cnt", pulse_cnt, 0);
        m_mode = 0;
        m_last = 0;
      end else begin
        case (m_mode)
          1: begin e_pin = m_pin[m_idx]; e_busy = 1; e_done = 0; e_cnt = m_cnt[m_idx]; end
          2: begin e_pin = 1; e_busy = 1; e_done = 1; e_cnt = m_done_cnt; end
          default: begin e_pin = 1; e_busy = 0; e_done = 0; e_cnt = m_last; end
        endcase
        chk("model_pin", pin_out, e_pin);
        chk("model_busy", busy, e_busy);
        chk("model_done", done_sig, e_done);
        chk("model_cnt", pulse_cnt, e_cnt);

        case (m_mode)
          0: begin
            if (start_sig) begin
              m_l = (low_len == 0) ? 1 : int'(low_len);
              m_h = (high_len == 0) ? 1 : int'(high_len);
              m_n = int'(pulse_num);
              m_last = 0;
              $display("txn start low=%0d high=%0d num=%0d t=%0t", low_len, high_len, pulse_num, $time);
              if (m_n == 0) begin
                m_mode = 2;
                m_done_cnt = 0;
              end else begin
                m_pin.delete();
                m_cnt.delete();
                for (int p = 0; p < m_n; p++) begin
                  for (int c = 0; c < m_l; c++) begin m_pin.push_back(1'b0); m_cnt.push_back(p); end
                  if (p < m_n - 1)
                    for (int c = 0; c < m_h; c++) begin m_pin.push_back(1'b1); m_cnt.push_back(p + 1); end
                end
                m_mode = 1;
                m_idx = 0;
              end
            end
          end
          1: begin
            if (abort_sig) begin
              m_mode = 2;
              m_done_cnt = m_cnt[m_idx];
            end else if (m_idx == m_pin.size() - 1) begin
              m_mode = 2;
              m_done_cnt = m_n;
            end else begin
              m_idx++;
            end
          end
          default: begin
            m_mode = 0;
            m_last = m_done_cnt;
          end
        endcase
      end
    end
  end

  task automatic start_train(input int l, input int h, input int n);
    @(posedge clk);
    #1;
    low_len = CNT_W'(l);
    high_len = CNT_W'(h);
    pulse_num = NUM_W'(n);
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    start_sig = 1'b0;
  endtask

  // pins bit k-1 is the required pin level in cycle T+k; checks run through T+done_at+1.
  task automatic run_lit(input string name, input logic [31:0] pins, input int done_at, input int cnt_exp);
    for (int k = 1; k <= done_at + 1; k++) begin
      @(negedge clk);
      chk({name, "_pin"}, pin_out, pins[k-1]);
      chk({name, "_busy"}, busy, (k <= done_at));
      chk({name, "_done"}, done_sig, (k == done_at));
      if (k == done_at) chk({name, "_cnt"}, pulse_cnt, cnt_exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_pin", pin_out, 1);
    chk("post_rst_busy", busy, 0);

    start_train(3, 2, 2);
    run_lit("basic", 32'b1100011000, 9, 2);

    start_train(0, 0, 3);
    run_lit("zero_len", 32'b1101010, 6, 3);

    start_train(5, 5, 0);
    run_lit("zero_num", 32'b11, 1, 0);

    // start held high for the whole train and into the first idle cycle
    start_train(4, 4, 1);
    start_sig = 1'b1;
    run_lit("restart", 32'b110000, 5, 1);
    @(negedge clk);
    chk("restart_low_pin", pin_out, 0);
    chk("restart_low_busy", busy, 1);
    @(posedge clk);
    #1 start_sig = 1'b0;
    repeat (6) @(posedge clk);

    start_train(10, 2, 5);
    fork
      run_lit("abort", 32'b11000110000000000, 16, 1);
      begin
        repeat (14) @(posedge clk);
        #1 abort_sig = 1'b1;
        @(posedge clk);
        #1 abort_sig = 1'b0;
      end
    join

    start_train(10, 0, 1);
    repeat (3) @(negedge clk);
    chk("pre_rst_low", pin_out, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pin", pin_out, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", pulse_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (1500) begin
      @(posedge clk);
      #1;
      start_sig = ($urandom_range(0, 4) == 0);
      abort_sig = ($urandom_range(0, 19) == 0);
      low_len = CNT_W'($urandom_range(0, 5));
      high_len = CNT_W'($urandom_range(0, 5));
      pulse_num = NUM_W'($urandom_range(0, 4));
    end
    @(posedge clk);
    #1;
    start_sig = 1'b0;
    abort_sig = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("final_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
